vga_timing_gen: RTL and testbench
=================================

Name: vga_timing_gen

Overview:
- Upstream raster source for every on-screen overlay condition block (axis labels, unit text such as the time/div legend, grid, waveform).
- Generates free-running horizontal/vertical pixel counters and emits them as VGA_horzCoord/VGA_vertCoord.
- Generates VGA sync and active-video signals, delayed to line up with the downstream registered RGB stage.
- Default timing is 1280x1024 @ 60 Hz on a 108 MHz pixel clock.

Parameters:
H_ACTIVE, 1280, visible pixels per line
H_FP, 48, horizontal front porch (pixels)
H_SYNC, 112, horizontal sync width (pixels)
H_BP, 248, horizontal back porch (pixels); H_TOTAL = sum = 1688
V_ACTIVE, 1024, visible lines per frame
V_FP, 1, vertical front porch (lines)
V_SYNC, 3, vertical sync width (lines)
V_BP, 38, vertical back porch (lines); V_TOTAL = sum = 1066
SYNC_POL, 1, active level of VGA_HS/VGA_VS (1 = positive)
PIPE_DELAY, 1, cycles by which VGA_HS/VGA_VS/VGA_active are delayed relative to the coordinates (0..7)

Ports:
CLK_VGA  input  1  pixel clock (108 MHz); the single clock of the block
RESET  input  1  synchronous, active-high reset
VGA_horzCoord  output  12  current pixel column, 0..H_TOTAL-1
VGA_vertCoord  output  12  current line, 0..V_TOTAL-1
VGA_HS  output  1  horizontal sync, delayed by PIPE_DELAY
VGA_VS  output  1  vertical sync, delayed by PIPE_DELAY
VGA_active  output  1  visible-region flag, delayed by PIPE_DELAY
line_end  output  1  one-cycle pulse while VGA_horzCoord == H_TOTAL-1 (undelayed)
frame_start  output  1  one-cycle pulse while coords == (0,0) (undelayed)
frame_count  output  16  completed-frame counter

Behaviour:
- Interface: one clock, CLK_VGA. RESET is synchronous and active-high, sampled on the CLK_VGA rising edge.
- Counters:
  - h_cnt increments every cycle and wraps H_TOTAL-1 -> 0.
  - v_cnt increments only on the h wrap edge and wraps V_TOTAL-1 -> 0 on the edge where both counters wrap.
  - VGA_horzCoord/VGA_vertCoord are the counter registers themselves, with zero latency from counter state.
- Decode, undelayed and aligned to the coordinates in the same cycle:
  - hs_raw = SYNC_POL when H_ACTIVE+H_FP <= h < H_ACTIVE+H_FP+H_SYNC, else ~SYNC_POL.
  - vs_raw uses the same rule with the V parameters on v.
  - act_raw = (h < H_ACTIVE) && (v < V_ACTIVE).
  - Decodes are computed from the next-state counter values and registered, so there are no combinational output paths.
- Delay line:
  - hs_raw/vs_raw/act_raw pass through a PIPE_DELAY-deep shift register. PIPE_DELAY=0 means the outputs equal the raw decodes.
  - Purpose: downstream overlay conditions are combinational and the RGB mux is registered once, so default 1 keeps sync aligned with colour.
- line_end and frame_start are undelayed.
- frame_count increments by 1 on the edge where (h,v) wraps from (H_TOTAL-1,V_TOTAL-1) to (0,0). It wraps 0xFFFF -> 0x0000.
- Reset, while RESET=1 at the edge:
  - h_cnt=0, v_cnt=0, frame_count=0.
  - All delay-line stages are loaded with the inactive values (sync = ~SYNC_POL, active = 0).
  - VGA_HS/VGA_VS = ~SYNC_POL, VGA_active=0, line_end=0, frame_start=0.
- After reset:
  - First cycle after RESET falls: coords (0,0), frame_start=1, frame_count=0.
  - VGA_active rises PIPE_DELAY cycles later. With PIPE_DELAY=0 it rises in that same cycle.
- Reset mid-frame has the same effect at any (h,v) and does not increment frame_count.
- Width rule: all compares are 12-bit unsigned. H_TOTAL and V_TOTAL must be <= 4096; an elaboration check fires otherwise.
- Boundaries:
  - h = H_ACTIVE-1 is the last active pixel; H_ACTIVE is the first blank pixel.
  - v = V_ACTIVE-1 is the last active line.
  - Sync intervals are inclusive at the start and exclusive at the end.

Test Plan:
- Reset release -> first cycle: coords (0,0), frame_start=1. With PIPE_DELAY=1: VGA_active=0 that cycle and 1 the next; VGA_HS=VGA_VS=0.
- Run one line -> line_end pulses exactly once at h=1687. Next cycle coords (0,1). VGA_HS high for exactly 112 cycles, first at the (delayed) h=1328 slot.
- Run a full frame (1688*1066 = 1,799,408 cycles) -> frame_count goes 0 -> 1 at the (0,0) return. VGA_VS high for 3 lines starting at line 1025. VGA_active high for exactly 1280*1024 cycles.
- Check at (245,940) and (1279,1023) -> raw active=1. At (1280,0) and (0,1024) -> raw active=0. Delayed outputs match with a shift of PIPE_DELAY cycles.
- Assert RESET for 1 cycle at (700,500) -> next cycle coords (0,0), frame_count unchanged-to-0, sync outputs inactive, no spurious frame_count increment.
- Instance with PIPE_DELAY=0, SYNC_POL=0 -> VGA_HS low exactly for h in 1328..1439 in the same cycle as the coordinates; idle level is 1.

Source files
------------

// File: rtl/vga_timing_gen.sv
// Raster timing source: free-running pixel/line counters, registered sync and
// active decodes, and a configurable delay line that aligns sync with registered RGB.
module vga_timing_gen #(
  parameter int unsigned H_ACTIVE   = 1280,
  parameter int unsigned H_FP       = 48,
  parameter int unsigned H_SYNC     = 112,
  parameter int unsigned H_BP       = 248,
  parameter int unsigned V_ACTIVE   = 1024,
  parameter int unsigned V_FP       = 1,
  parameter int unsigned V_SYNC     = 3,
  parameter int unsigned V_BP       = 38,
  parameter bit          SYNC_POL   = 1'b1,
  parameter int unsigned PIPE_DELAY = 1
) (
  input  logic        CLK_VGA,
  input  logic        RESET,
  output logic [11:0] VGA_horzCoord,
  output logic [11:0] VGA_vertCoord,
  output logic        VGA_HS,
  output logic        VGA_VS,
  output logic        VGA_active,
  output logic        line_end,
  output logic        frame_start,
  output logic [15:0] frame_count
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  if (H_TOTAL > 4096 || V_TOTAL > 4096 || PIPE_DELAY > 7) begin : g_bad_params
    $error("vga_timing_gen: totals must fit 12 bits and PIPE_DELAY must be 0..7");
  end

  localparam logic [11:0] H_LAST      = 12'(H_TOTAL - 1);
  localparam logic [11:0] V_LAST      = 12'(V_TOTAL - 1);
  localparam logic [11:0] H_ACT_END   = 12'(H_ACTIVE);
  localparam logic [11:0] V_ACT_END   = 12'(V_ACTIVE);
  localparam logic [11:0] H_SYNC_BEG  = 12'(H_ACTIVE + H_FP);
  localparam logic [11:0] H_SYNC_END  = 12'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [11:0] V_SYNC_BEG  = 12'(V_ACTIVE + V_FP);
  localparam logic [11:0] V_SYNC_END  = 12'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [2:0]  IDLE_VEC    = {~SYNC_POL, ~SYNC_POL, 1'b0};

  logic [11:0] h_q, h_d, v_q, v_d;
  logic [15:0] fc_q;
  logic        run_q;
  logic        h_wrap, v_wrap, frame_wrap;
  logic        hs_raw_q, vs_raw_q, act_raw_q, line_end_q, frame_start_q;
  logic        hs_raw_d, vs_raw_d, act_raw_d, line_end_d, frame_start_d;

  // Counters hold at (0,0) for the first cycle after reset so that cycle shows
  // frame_start; from then on they free-run.
  always_comb begin
    h_wrap     = (h_q == H_LAST);
    v_wrap     = (v_q == V_LAST);
    frame_wrap = run_q && h_wrap && v_wrap;
    h_d        = h_q;
    v_d        = v_q;
    if (run_q) begin
      h_d = h_wrap ? 12'd0 : h_q + 12'd1;
      if (h_wrap) begin
        v_d = v_wrap ? 12'd0 : v_q + 12'd1;
      end
    end
  end

  always_comb begin
    hs_raw_d      = ((h_d >= H_SYNC_BEG) && (h_d < H_SYNC_END)) ? SYNC_POL : ~SYNC_POL;
    vs_raw_d      = ((v_d >= V_SYNC_BEG) && (v_d < V_SYNC_END)) ? SYNC_POL : ~SYNC_POL;
    act_raw_d     = (h_d < H_ACT_END) && (v_d < V_ACT_END);
    line_end_d    = (h_d == H_LAST);
    frame_start_d = (h_d == 12'd0) && (v_d == 12'd0);
  end

  always_ff @(posedge CLK_VGA) begin
    if (RESET) begin
      h_q           <= 12'd0;
      v_q           <= 12'd0;
      run_q         <= 1'b0;
      fc_q          <= 16'd0;
      hs_raw_q      <= ~SYNC_POL;
      vs_raw_q      <= ~SYNC_POL;
      act_raw_q     <= 1'b0;
      line_end_q    <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      h_q           <= h_d;
      v_q           <= v_d;
      run_q         <= 1'b1;
      hs_raw_q      <= hs_raw_d;
      vs_raw_q      <= vs_raw_d;
      act_raw_q     <= act_raw_d;
      line_end_q    <= line_end_d;
      frame_start_q <= frame_start_d;
      if (frame_wrap) begin
        fc_q <= fc_q + 16'd1;
      end
    end
  end

  logic [2:0] raw_vec;
  logic [2:0] dly_out;
  assign raw_vec = {hs_raw_q, vs_raw_q, act_raw_q};

  if (PIPE_DELAY == 0) begin : g_nodly
    assign dly_out = raw_vec;
  end else begin : g_dly
    for (genvar gi = 0; gi < PIPE_DELAY; gi++) begin : g_stage
      logic [2:0] q;
      logic [2:0] src;
      if (gi == 0) begin : g_first
        assign src = raw_vec;
      end else begin : g_next
        assign src = g_stage[gi-1].q;
      end
      always_ff @(posedge CLK_VGA) begin
        if (RESET) q <= IDLE_VEC;
        else       q <= src;
      end
    end
    assign dly_out = g_stage[PIPE_DELAY-1].q;
  end

  assign VGA_horzCoord = h_q;
  assign VGA_vertCoord = v_q;
  assign VGA_HS        = dly_out[2];
  assign VGA_VS        = dly_out[1];
  assign VGA_active    = dly_out[0];
  assign line_end      = line_end_q;
  assign frame_start   = frame_start_q;
  assign frame_count   = fc_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench: a small-timing instance (PIPE_DELAY=1, positive sync) and a
// default-timing instance (PIPE_DELAY=0, negative sync) run side by side.
module tb_vga_timing_gen;

  localparam int NS = 1701;

  logic        clk;
  logic        rst;
  logic [11:0] a_h, a_v, b_h, b_v;
  logic        a_hs, a_vs, a_act, a_le, a_fs;
  logic        b_hs, b_vs, b_act, b_le, b_fs;
  logic [15:0] a_fc, b_fc;

  int n_tests = 0;
  int n_fail  = 0;

  int ah[NS], av[NS], ahs[NS], avs[NS], aact[NS], ale[NS], afs[NS], afc[NS];
  int bh[NS], bv[NS], bhs[NS], bact[NS], ble[NS];

  // H: 16 active, sync 18..20, total 25.  V: 8 active, sync lines 9..10, total 14.
  vga_timing_gen #(
    .H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(4),
    .V_ACTIVE(8),  .V_FP(1), .V_SYNC(2), .V_BP(3),
    .SYNC_POL(1'b1), .PIPE_DELAY(1)
  ) dut_a (
    .CLK_VGA(clk), .RESET(rst),
    .VGA_horzCoord(a_h), .VGA_vertCoord(a_v),
    .VGA_HS(a_hs), .VGA_VS(a_vs), .VGA_active(a_act),
    .line_end(a_le), .frame_start(a_fs), .frame_count(a_fc)
  );

  vga_timing_gen #(
    .SYNC_POL(1'b0), .PIPE_DELAY(0)
  ) dut_b (
    .CLK_VGA(clk), .RESET(rst),
    .VGA_horzCoord(b_h), .VGA_vertCoord(b_v),
    .VGA_HS(b_hs), .VGA_VS(b_vs), .VGA_active(b_act),
    .line_end(b_le), .frame_start(b_fs), .frame_count(b_fc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  initial begin
    int cnt, bad;
    bit found;

    rst = 1'b1;
    tick(); tick(); tick();
    check("rst_a_h", 32'(a_h), 0);
    check("rst_a_v", 32'(a_v), 0);
    check("rst_a_hs", 32'(a_hs), 0);
    check("rst_a_vs", 32'(a_vs), 0);
    check("rst_a_act", 32'(a_act), 0);
    check("rst_a_le", 32'(a_le), 0);
    check("rst_a_fs", 32'(a_fs), 0);
    check("rst_a_fc", 32'(a_fc), 0);
    check("rst_b_hs", 32'(b_hs), 1);
    check("rst_b_vs", 32'(b_vs), 1);
    check("rst_b_act", 32'(b_act), 0);

    rst = 1'b0;
    tick();
    for (int k = 0; k < NS; k++) begin
      ah[k] = int'(a_h); av[k] = int'(a_v); ahs[k] = int'(a_hs); avs[k] = int'(a_vs);
      aact[k] = int'(a_act); ale[k] = int'(a_le); afs[k] = int'(a_fs); afc[k] = int'(a_fc);
      bh[k] = int'(b_h); bv[k] = int'(b_v); bhs[k] = int'(b_hs); bact[k] = int'(b_act);
      ble[k] = int'(b_le);
      $display("[TB] cycle %0d A=(%0d,%0d) hs=%0d vs=%0d act=%0d B=(%0d,%0d) hs=%0d act=%0d",
               k, ah[k], av[k], ahs[k], avs[k], aact[k], bh[k], bv[k], bhs[k], bact[k]);
      tick();
    end

    // First cycle after reset release
    check("first_a_h", 32'(ah[0]), 0);
    check("first_a_v", 32'(av[0]), 0);
    check("first_a_fs", 32'(afs[0]), 1);
    check("first_a_act", 32'(aact[0]), 0);
    check("first_a_hs", 32'(ahs[0]), 0);
    check("first_a_vs", 32'(avs[0]), 0);
    check("first_a_fc", 32'(afc[0]), 0);
    check("first_b_act", 32'(bact[0]), 1);
    check("first_b_hs", 32'(bhs[0]), 1);
    check("second_a_act", 32'(aact[1]), 1);
    check("second_a_h", 32'(ah[1]), 1);
    check("second_a_fs", 32'(afs[1]), 0);

    bad = 0;
    for (int k = 0; k < 350; k++)
      if (ah[k] != k % 25 || av[k] != k / 25) bad++;
    check("a_coord_sequence", 32'(bad), 0);

    // Line end / first line sync
    cnt = 0;
    for (int k = 0; k < 25; k++) cnt += ale[k];
    check("a_line_end_count", 32'(cnt), 1);
    check("a_line_end_at_24", 32'(ale[24]), 1);
    check("a_next_line_h", 32'(ah[25]), 0);
    check("a_next_line_v", 32'(av[25]), 1);
    cnt = 0;
    for (int k = 1; k <= 25; k++) cnt += ahs[k];
    check("a_hs_line_count", 32'(cnt), 3);
    check("a_hs_before", 32'(ahs[18]), 0);
    check("a_hs_first", 32'(ahs[19]), 1);
    check("a_hs_last", 32'(ahs[21]), 1);
    check("a_hs_after", 32'(ahs[22]), 0);

    // Whole frame
    cnt = 0;
    for (int k = 1; k <= 350; k++) cnt += aact[k];
    check("a_act_frame_count", 32'(cnt), 128);
    cnt = 0;
    for (int k = 1; k <= 350; k++) cnt += avs[k];
    check("a_vs_frame_count", 32'(cnt), 50);
    check("a_vs_before", 32'(avs[225]), 0);
    check("a_vs_first", 32'(avs[226]), 1);
    check("a_vs_last", 32'(avs[275]), 1);
    check("a_vs_after", 32'(avs[276]), 0);
    check("a_act_15_7", 32'(aact[191]), 1);
    check("a_act_5_6", 32'(aact[156]), 1);
    check("a_act_16_0", 32'(aact[17]), 0);
    check("a_act_0_8", 32'(aact[201]), 0);

    bad = 0;
    for (int k = 1; k <= 350; k++) begin
      if (aact[k] != int'(ah[k-1] < 16 && av[k-1] < 8)) bad++;
      if (ahs[k]  != int'(ah[k-1] >= 18 && ah[k-1] < 21)) bad++;
      if (avs[k]  != int'(av[k-1] >= 9 && av[k-1] < 11)) bad++;
    end
    check("a_delayed_decode_model", 32'(bad), 0);
    bad = 0;
    for (int k = 0; k <= 350; k++) begin
      if (ale[k] != int'(ah[k] == 24)) bad++;
      if (afs[k] != int'(ah[k] == 0 && av[k] == 0)) bad++;
    end
    check("a_undelayed_pulse_model", 32'(bad), 0);

    check("a_fc_before_wrap", 32'(afc[349]), 0);
    check("a_h_before_wrap", 32'(ah[349]), 24);
    check("a_v_before_wrap", 32'(av[349]), 13);
    check("a_fc_after_wrap", 32'(afc[350]), 1);
    check("a_h_after_wrap", 32'(ah[350]), 0);
    check("a_v_after_wrap", 32'(av[350]), 0);
    check("a_fs_after_wrap", 32'(afs[350]), 1);
    check("a_fc_four_frames", 32'(afc[1700]), 4);

    // Default-timing instance, negative sync, no delay
    bad = 0; cnt = 0;
    for (int k = 0; k < 1688; k++) begin
      if (bhs[k] != int'(!(bh[k] >= 1328 && bh[k] < 1440))) bad++;
      if (bhs[k] == 0) cnt++;
    end
    check("b_hs_model", 32'(bad), 0);
    check("b_hs_low_count", 32'(cnt), 112);
    check("b_hs_1327", 32'(bhs[1327]), 1);
    check("b_hs_1328", 32'(bhs[1328]), 0);
    check("b_hs_1439", 32'(bhs[1439]), 0);
    check("b_hs_1440", 32'(bhs[1440]), 1);
    check("b_act_1279", 32'(bact[1279]), 1);
    check("b_act_1280", 32'(bact[1280]), 0);
    cnt = 0;
    for (int k = 0; k < 1688; k++) cnt += bact[k];
    check("b_act_line_count", 32'(cnt), 1280);
    cnt = 0;
    for (int k = 0; k < 1688; k++) cnt += ble[k];
    check("b_line_end_count", 32'(cnt), 1);
    check("b_line_end_1687", 32'(ble[1687]), 1);
    check("b_next_line_h", 32'(bh[1688]), 0);
    check("b_next_line_v", 32'(bv[1688]), 1);

    // Mid-frame reset at A=(7,5)
    found = 1'b0;
    for (int i = 0; i < 500 && !found; i++) begin
      if (a_h == 12'd7 && a_v == 12'd5) found = 1'b1;
      else tick();
    end
    check("midrst_reached", 32'(found), 1);
    check("midrst_fc_before", 32'(a_fc), 5);
    rst = 1'b1;
    tick();
    check("midrst_a_h", 32'(a_h), 0);
    check("midrst_a_v", 32'(a_v), 0);
    check("midrst_a_fc", 32'(a_fc), 0);
    check("midrst_a_hs", 32'(a_hs), 0);
    check("midrst_a_vs", 32'(a_vs), 0);
    check("midrst_a_act", 32'(a_act), 0);
    check("midrst_a_le", 32'(a_le), 0);
    check("midrst_a_fs", 32'(a_fs), 0);
    check("midrst_b_hs", 32'(b_hs), 1);
    check("midrst_b_h", 32'(b_h), 0);
    rst = 1'b0;
    tick();
    check("postrst_a_h", 32'(a_h), 0);
    check("postrst_a_v", 32'(a_v), 0);
    check("postrst_a_fs", 32'(a_fs), 1);
    check("postrst_a_fc", 32'(a_fc), 0);
    check("postrst_a_act", 32'(a_act), 0);
    tick();
    check("postrst2_a_h", 32'(a_h), 1);
    check("postrst2_a_act", 32'(a_act), 1);
    check("postrst2_a_fc", 32'(a_fc), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
